pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/mips_cpu_pkg.sv | 28 ++
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg
//   Types and constants shared between the MIPS pipeline stages.
//   - pipe_state_enum : occupancy state of a two-entry pipeline register
//                       (EMPTY / ONE / FULL). Its encoding is the held count.
//   - id_exe_bundle_t : payload carried from ID to EXE. Instantiate
//                       pipe_stage_reg with WIDTH = ID_EXE_W.
//   - ID_EXE_ZERO     : all-zero bundle, which the pipeline treats as a NOP.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_enum;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
  } id_exe_bundle_t;

  localparam int ID_EXE_W = $bits(id_exe_bundle_t);

  localparam id_exe_bundle_t ID_EXE_ZERO = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Fully registered two-entry pipeline register with a skid buffer. It
//   streams one bundle per cycle with one cycle of latency. It breaks the
//   ready path, so in_ready never depends combinationally on out_ready.
//
// Ports
//   cpu_clk_50M  in   sole clock, rising edge
//   cpu_rst_n    in   synchronous active-low reset
//   in_valid     in   upstream offers in_data
//   in_ready     out  stage can take a bundle this cycle (not FULL)
//   in_data      in   WIDTH-bit upstream bundle
//   out_valid    out  main entry holds a bundle
//   out_ready    in   downstream consumes out_data this cycle
//   out_data     out  main entry; all-zero whenever out_valid=0
//   flush        in   discard every held bundle (branch/exception kill)
//   occupancy    out  held bundles 0..2 (also the FSM state encoding)
//   stall_cnt    out  saturating count of cycles with out_valid & !out_ready
//   stall_clr    in   zero stall_cnt; wins over a same-cycle increment
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. valid never waits on ready. Once a bundle is offered, the offer
// stays asserted and the bundle stays unchanged until it is taken. The only
// exceptions are flush and reset.
module pipe_stage_reg
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 160,
  parameter int CNT_W = 16
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  pipe_state_enum   state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic accept;
  logic take;

  // All outputs come from registers only. This keeps out_ready from
  // reaching in_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  // main_q is already zeroed whenever the stage drains. The gate makes the
  // NOP bubble explicit on the output.
  assign out_data  = out_valid ? main_q : '0;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Kill everything, including a bundle accepted this cycle. A
      // coincident take has already been seen by downstream.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_d = in_data;
          end else if (accept) begin
            // Downstream stalled: park the new bundle behind main.
            state_d = FULL;
            skid_d  = in_data;
          end else if (take) begin
            state_d = EMPTY;
            main_d  = '0;
          end
        end
        FULL: begin
          // in_ready is low, so no accept can happen here.
          if (take) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Stall counter. It saturates instead of wrapping, and flush leaves it
  // alone.
  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Bench for pipe_stage_reg (WIDTH = ID/EXE bundle width, CNT_W = 4).
//   The reference model is a queue of held bundles. Its head is out_data, its
//   size is the occupancy, and room in the queue is in_ready. Directed phases
//   pin literal values. A random phase follows, checked only by the model.
module tb_pipe_stage_reg;
  import mips_cpu_pkg::*;

  localparam int W     = ID_EXE_W;
  localparam int CNT_W = 4;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_clr;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush       (flush),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt),
    .stall_clr   (stall_clr)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard model: exp_q holds the bundles the stage owns, oldest first.
  logic [W-1:0] exp_q[$];
  int           m_stall    = 0;
  bit           model_live = 1'b0;

  always @(posedge clk) begin
    bit m_take, m_accept;
    if (!rst_n) begin
      exp_q.delete();
      m_stall = 0;
    end else begin
      m_take   = (exp_q.size() > 0) && out_ready;
      m_accept = in_valid && (exp_q.size() < 2);
      if (stall_clr)                                           m_stall = 0;
      else if (exp_q.size() > 0 && !out_ready && m_stall < SMAX) m_stall++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_take)   void'(exp_q.pop_front());
        if (m_accept) exp_q.push_back(in_data);
      end
    end
    model_live = 1'b1;
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: on every falling edge, check all outputs against the
  // model.
  always @(negedge clk) begin
    if (model_live) begin
      chk("m_out_valid", W'(out_valid), W'(exp_q.size() > 0));
      chk("m_out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : '0);
      chk("m_occupancy", W'(occupancy), W'(exp_q.size()));
      chk("m_in_ready", W'(in_ready), W'(exp_q.size() < 2));
      chk("m_stall_cnt", W'(stall_cnt), W'(m_stall));
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
  endtask

  function automatic logic [W-1:0] rand_bundle();
    logic [W-1:0] b;
    for (int k = 0; k < W / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    drive(1'b0, '0, 1'b0);
    step(); step();
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_occupancy", W'(occupancy), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_stall_cnt", W'(stall_cnt), '0);
    rst_n = 1'b1;

    // Streaming: 0x1..0x8 with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1);
      step();
      chk("stream_data", out_data, W'(i));
      chk("stream_occ", W'(occupancy), W'(1));
    end
    drive(1'b0, '0, 1'b1);
    step();
    chk("stream_drain_valid", W'(out_valid), '0);

    // Backpressure: 0xA, 0xB against a stalled downstream.
    drive(1'b1, W'('hA), 1'b0);
    step();
    chk("bp_first", out_data, W'('hA));
    drive(1'b1, W'('hB), 1'b0);
    step();
    chk("bp_occ_full", W'(occupancy), W'(2));
    chk("bp_in_ready", W'(in_ready), '0);
    chk("bp_head", out_data, W'('hA));
    drive(1'b0, '0, 1'b1);
    step();
    chk("bp_rel_b", out_data, W'('hB));
    step();
    chk("bp_empty", W'(out_valid), '0);

    // Flush in FULL while 0xC is offered.
    drive(1'b1, W'('h1A), 1'b0); step();
    drive(1'b1, W'('h1B), 1'b0); step();
    chk("fl_pre_occ", W'(occupancy), W'(2));
    drive(1'b1, W'('hC), 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_occ", W'(occupancy), '0);
    chk("fl_valid", W'(out_valid), '0);
    chk("fl_data", out_data, '0);
    drive(1'b0, '0, 1'b1);
    step();
    chk("fl_no_c", W'(out_valid), '0);

    // Flush coincident with an accept in ONE drops the incoming bundle.
    drive(1'b1, W'('h21), 1'b0); step();
    drive(1'b1, W'('hE), 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_acc_occ", W'(occupancy), '0);
    drive(1'b0, '0, 1'b1);

    // Stall saturation at 15, then a clear while the stall persists.
    stall_clr = 1'b1; step(); stall_clr = 1'b0;
    chk("st_clr0", W'(stall_cnt), '0);
    drive(1'b1, W'('h55), 1'b0); step();
    drive(1'b0, '0, 1'b0);
    repeat (20) step();
    chk("st_sat", W'(stall_cnt), W'(15));
    stall_clr = 1'b1; step(); stall_clr = 1'b0;
    chk("st_clr", W'(stall_cnt), '0);

    // Reset in the middle of FULL.
    drive(1'b1, W'('h56), 1'b0); step();
    chk("rf_full", W'(occupancy), W'(2));
    rst_n = 1'b0; flush = 1'b1; stall_clr = 1'b0;
    drive(1'b1, W'('h57), 1'b1);
    step();
    rst_n = 1'b1; flush = 1'b0;
    chk("rf_valid", W'(out_valid), '0);
    chk("rf_data", out_data, '0);
    chk("rf_occ", W'(occupancy), '0);
    chk("rf_in_ready", W'(in_ready), W'(1));
    chk("rf_stall", W'(stall_cnt), '0);
    drive(1'b1, W'('hD), 1'b1);
    step();
    chk("rf_d", out_data, W'('hD));
    chk("rf_d_occ", W'(occupancy), W'(1));
    drive(1'b0, '0, 1'b1);
    step();
    chk("rf_d_alone", W'(out_valid), '0);

    // Random traffic, checked by the model on every cycle.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), rand_bundle(), ($urandom_range(0, 3) != 0));
      flush     = ($urandom_range(0, 19) == 0);
      stall_clr = ($urandom_range(0, 29) == 0);
      step();
    end
    drive(1'b0, '0, 1'b1);
    flush = 1'b0; stall_clr = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
